// File: rtl/sum_accel_slave.sv
// sum_accel_slave: Avalon-MM slave that queues words in a FIFO and sums them.
// Define SUM_ACCEL_SATURATE_EN for a saturating RESULT with sticky SAT flag.
module sum_accel_slave #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        waitrequest,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_ACC
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q;
  logic          en_q, ie_q, done_q;
  logic [31:0]   result_q, count_q, op_q;
  logic [31:0]   rdata_q;
  logic          rvalid_q;

  logic        wr_ctrl, wr_data, push, pop;
  logic        clr, full, empty, rd_ok;
  logic        done_set, sat_flag;
  logic [31:0] sum, rd_mux, status;

  assign wr_ctrl = write && (address == 3'd0);
  assign wr_data = write && (address == 3'd1);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign push    = wr_data && !full;
  assign clr     = wr_ctrl && writedata[1];
  assign rd_ok   = read && !write;

  assign waitrequest   = wr_data && full;
  assign readdata      = rdata_q;
  assign readdatavalid = rvalid_q;
  assign irq           = done_q && ie_q;

  // DONE fires when an ACC leaves nothing behind to process
  assign done_set = (state_q == S_ACC) && empty && !push;

`ifdef SUM_ACCEL_SATURATE_EN
  logic [32:0] sum_w;
  logic        sat_q;
  assign sum_w    = {1'b0, result_q} + {1'b0, op_q};
  assign sum      = sum_w[32] ? 32'hFFFF_FFFF : sum_w[31:0];
  assign sat_flag = sat_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sat_q <= 1'b0;
    end else if (state_q == S_ACC && sum_w[32]) begin
      sat_q <= 1'b1;
    end
  end
`else
  assign sum      = result_q + op_q;
  assign sat_flag = 1'b0;
`endif

  assign status = {16'b0, 8'(level_q), 3'b0, sat_flag,
                   done_q, full, empty, state_q != S_IDLE};

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = {29'b0, ie_q, 1'b0, en_q};
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = result_q;
      3'd4:    rd_mux = count_q;
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: if (en_q && !empty) state_d = S_POP;
      S_POP: begin
        pop     = 1'b1;
        state_d = S_ACC;
      end
      S_ACC: state_d = (en_q && !empty) ? S_POP : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= rd_ok;
      rdata_q  <= rd_ok ? rd_mux : '0;
      if (wr_ctrl) begin
        en_q <= writedata[0];
        ie_q <= writedata[2];
      end
      if (rd_ok && address == 3'd2) done_q <= 1'b0;
      if (done_set) done_q <= 1'b1;
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        op_q   <= mem_q[rptr_q];
      end
      if (push && !pop) level_q <= level_q + LW'(1);
      if (pop && !push) level_q <= level_q - LW'(1);
      if (state_q == S_ACC) begin
        result_q <= sum;
        count_q  <= count_q + 32'd1;
      end
      if (clr) begin
        state_q  <= S_IDLE;
        wptr_q   <= '0;
        rptr_q   <= '0;
        level_q  <= '0;
        done_q   <= 1'b0;
        result_q <= '0;
        count_q  <= '0;
        op_q     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sum_accel_slave.sv
// tb_sum_accel_slave: randomized self-checking bench for sum_accel_slave.
// Reference model sums queued words with plain arithmetic.
module tb_sum_accel_slave;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        irq;

  int errors = 0;
  int checks = 0;

  sum_accel_slave #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .readdatavalid(readdatavalid),
    .waitrequest(waitrequest),
    .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_total(input logic [31:0] w[$]);
    longint unsigned acc = 0;
    foreach (w[i]) begin
`ifdef SUM_ACCEL_SATURATE_EN
      acc = acc + w[i];
      if (acc > 64'hFFFF_FFFF) acc = 64'hFFFF_FFFF;
`else
      acc = (acc + w[i]) % 64'h1_0000_0000;
`endif
    end
    return acc[31:0];
  endfunction

  function automatic logic ref_sat(input logic [31:0] w[$]);
    longint unsigned acc = 0;
    foreach (w[i]) acc = acc + w[i];
`ifdef SUM_ACCEL_SATURATE_EN
    return acc > 64'hFFFF_FFFF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_status(input int lvl, input logic sat,
      input logic done, input logic busy);
    return (lvl << 8) | (sat << 4) | (done << 3) |
           ((lvl == DEPTH) << 2) | ((lvl == 0) << 1) | busy;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d,
      output int stalls);
    address = a;
    writedata = d;
    write = 1'b1;
    stalls = 0;
    #1;
    while (waitrequest && stalls < 200) begin
      tick();
      stalls++;
    end
    checks++;
    if (stalls >= 200) begin
      errors++;
      $display("FAIL write_timeout addr=%0d stalls=%0d limit=200", a, stalls);
    end
    tick();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic rv,
      output logic [31:0] d);
    address = a;
    read = 1'b1;
    tick();
    read = 1'b0;
    rv = readdatavalid;
    d = readdata;
  endtask

  task automatic test_reset();
    logic rv;
    logic [31:0] d;
    reset = 1'b1;
    read = 1'b0;
    write = 1'b0;
    address = '0;
    writedata = '0;
    repeat (3) tick();
    checks++;
    if ({readdata, readdatavalid, waitrequest, irq} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h want=0",
               {readdata, readdatavalid, waitrequest, irq});
    end
    reset = 1'b0;
    bus_read(3'd2, rv, d);
    checks++;
    if (rv !== 1'b1 || d !== 32'h2) begin
      errors++;
      $display("FAIL reset_status got=%b/%h want=1/00000002", rv, d);
    end
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_result got=%h want=0", d);
    end
    bus_read(3'd0, rv, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL reset_ctrl got=%h want=0", d);
    end
  endtask

  task automatic test_basic();
    int s;
    logic rv;
    logic [31:0] d;
    bus_write(3'd0, 32'h7, s);
    for (int i = 1; i <= 4; i++) bus_write(3'd1, 32'(i), s);
    repeat (30) tick();
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL basic_irq got=%b want=1", irq);
    end
    bus_read(3'd0, rv, d);
    checks++;
    if (d !== 32'h5) begin
      errors++;
      $display("FAIL basic_ctrl got=%h want=00000005", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want [3];
    logic [2:0] addrs [3];
    logic rv;
    logic [31:0] d;
    addrs = '{3'd3, 3'd4, 3'd2};
    want = '{32'hA, 32'h4, ref_status(0, 1'b0, 1'b1, 1'b0)};
    read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = addrs[i];
      tick();
      checks++;
      if (readdatavalid !== 1'b1 || readdata !== want[i]) begin
        errors++;
        $display("FAIL b2b_read%0d got=%b/%h want=1/%h",
                 i, readdatavalid, readdata, want[i]);
      end
    end
    read = 1'b0;
    tick();
    checks++;
    if (readdatavalid !== 1'b0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL b2b_tail rv=%b irq=%b want=0/0", readdatavalid, irq);
    end
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL b2b_done_clear got=%h want=00000002", d);
    end
  endtask

  task automatic test_random();
    int s;
    logic rv;
    logic [31:0] d, w;
    logic [31:0] q[$];
    for (int r = 0; r < 4; r++) begin
      q.delete();
      bus_write(3'd0, 32'h3, s);
      for (int i = 0; i < $urandom_range(12, 1); i++) begin
        w = $urandom;
        if (r == 1) w = w % 16;
        if (r == 2) w = w | 32'hF000_0000;
        q.push_back(w);
        bus_write(3'd1, w, s);
        repeat ($urandom_range(3, 0)) tick();
      end
      repeat (40) tick();
      bus_read(3'd3, rv, d);
      checks++;
      if (d !== ref_total(q)) begin
        errors++;
        $display("FAIL rand%0d_result got=%h want=%h", r, d, ref_total(q));
      end
      bus_read(3'd4, rv, d);
      checks++;
      if (d !== 32'(q.size())) begin
        errors++;
        $display("FAIL rand%0d_count got=%0d want=%0d", r, d, q.size());
      end
      bus_read(3'd2, rv, d);
      checks++;
      if (d !== ref_status(0, ref_sat(q), 1'b1, 1'b0) || irq !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_status got=%h irq=%b want=%h irq=0", r, d, irq,
                 ref_status(0, ref_sat(q), 1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_stall();
    int s, tot;
    logic rv;
    logic [31:0] d, w;
    logic [31:0] q[$];
    tot = 0;
    bus_write(3'd0, 32'h2, s);
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      q.push_back(w);
      bus_write(3'd1, w, s);
      tot += s;
    end
    checks++;
    if (tot !== 0) begin
      errors++;
      $display("FAIL stall_fill got=%0d stalls want=0", tot);
    end
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== ref_status(DEPTH, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL stall_full_status got=%h want=%h", d,
               ref_status(DEPTH, 1'b0, 1'b0, 1'b0));
    end
    w = $urandom;
    q.push_back(w);
    address = 3'd1;
    writedata = w;
    write = 1'b1;
    #1;
    repeat (3) tick();
    checks++;
    if (waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got=%b want=1", waitrequest);
    end
    write = 1'b0;
    #1;
    checks++;
    if (waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got=%b want=0", waitrequest);
    end
    bus_write(3'd0, 32'h1, s);
    bus_write(3'd1, w, s);
    checks++;
    if (s < 1 || s > 6) begin
      errors++;
      $display("FAIL stall_len got=%0d want=1..6", s);
    end
    repeat (40) tick();
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== ref_total(q)) begin
      errors++;
      $display("FAIL stall_result got=%h want=%h", d, ref_total(q));
    end
    bus_read(3'd4, rv, d);
    checks++;
    if (d !== 32'(DEPTH + 1)) begin
      errors++;
      $display("FAIL stall_count got=%0d want=%0d", d, DEPTH + 1);
    end
  endtask

  task automatic test_wrap();
    int s;
    logic rv;
    logic [31:0] d;
    logic [31:0] q[$];
    q = '{32'hFFFF_FFFF, 32'h2};
    bus_write(3'd0, 32'h3, s);
    foreach (q[i]) bus_write(3'd1, q[i], s);
    repeat (20) tick();
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== ref_total(q)) begin
      errors++;
      $display("FAIL wrap_result got=%h want=%h", d, ref_total(q));
    end
    bus_read(3'd2, rv, d);
    checks++;
    if (d[4] !== ref_sat(q)) begin
      errors++;
      $display("FAIL wrap_sat got=%b want=%b", d[4], ref_sat(q));
    end
  endtask

  task automatic test_clr_busy();
    int s;
    logic rv;
    logic [31:0] d;
    bus_write(3'd0, 32'h2, s);
    for (int i = 0; i < 6; i++) bus_write(3'd1, $urandom, s);
    bus_write(3'd0, 32'h1, s);
    repeat (2) tick();
    bus_write(3'd0, 32'h3, s);
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL clr_status got=%h want=00000002", d);
    end
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL clr_result got=%h want=0", d);
    end
    bus_read(3'd4, rv, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL clr_count got=%h want=0", d);
    end
    bus_read(3'd0, rv, d);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL clr_ctrl got=%h want=00000001", d);
    end
  endtask

  task automatic test_en_pause();
    int s, k;
    logic rv;
    logic [31:0] d, st, w;
    logic [31:0] q[$], part[$];
    bus_write(3'd0, 32'h2, s);
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      q.push_back(w);
      bus_write(3'd1, w, s);
    end
    repeat (5) tick();
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== ref_status(4, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL pause_queued got=%h want=%h", d,
               ref_status(4, 1'b0, 1'b0, 1'b0));
    end
    bus_write(3'd0, 32'h1, s);
    repeat (2) tick();
    bus_write(3'd0, 32'h0, s);
    repeat (10) tick();
    bus_read(3'd4, rv, d);
    k = int'(d);
    bus_read(3'd2, rv, st);
    for (int i = 0; i < k && i < 4; i++) part.push_back(q[i]);
    checks++;
    if (k < 1 || k > 3 || int'(st[15:8]) != 4 - k || st[0] !== 1'b0) begin
      errors++;
      $display("FAIL pause_partial count=%0d status=%h want=1..3 level=4-count",
               k, st);
    end
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== ref_total(part)) begin
      errors++;
      $display("FAIL pause_result got=%h want=%h", d, ref_total(part));
    end
    bus_write(3'd0, 32'h1, s);
    repeat (20) tick();
    bus_read(3'd3, rv, d);
    checks++;
    if (d !== ref_total(q)) begin
      errors++;
      $display("FAIL resume_result got=%h want=%h", d, ref_total(q));
    end
  endtask

  task automatic test_reset_mid();
    int s;
    logic rv;
    logic [31:0] d;
    bus_write(3'd0, 32'h7, s);
    for (int i = 0; i < 4; i++) bus_write(3'd1, $urandom, s);
    repeat (2) tick();
    reset = 1'b1;
    read = 1'b1;
    address = 3'd3;
    tick();
    checks++;
    if ({readdata, readdatavalid, waitrequest, irq} !== 35'd0) begin
      errors++;
      $display("FAIL rstmid_outputs got=%h want=0",
               {readdata, readdatavalid, waitrequest, irq});
    end
    reset = 1'b0;
    read = 1'b0;
    tick();
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_norv got=%b want=0", readdatavalid);
    end
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== 32'h2) begin
      errors++;
      $display("FAIL rstmid_status got=%h want=00000002", d);
    end
    bus_read(3'd0, rv, d);
    checks++;
    if (d !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_ctrl got=%h want=0", d);
    end
  endtask

  task automatic test_illegal();
    logic rv;
    logic [31:0] d;
    address = 3'd1;
    writedata = 32'h7;
    write = 1'b1;
    read = 1'b1;
    tick();
    write = 1'b0;
    read = 1'b0;
    checks++;
    if (readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_rv got=%b want=0", readdatavalid);
    end
    bus_read(3'd2, rv, d);
    checks++;
    if (d !== ref_status(1, 1'b0, 1'b0, 1'b0)) begin
      errors++;
      $display("FAIL illegal_level got=%h want=%h", d,
               ref_status(1, 1'b0, 1'b0, 1'b0));
    end
    bus_read(3'd1, rv, d);
    checks++;
    if (rv !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL data_read got=%b/%h want=1/0", rv, d);
    end
    bus_read(3'd6, rv, d);
    checks++;
    if (rv !== 1'b1 || d !== 32'h0) begin
      errors++;
      $display("FAIL hole_read got=%b/%h want=1/0", rv, d);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_stall();
    test_wrap();
    test_clr_busy();
    test_en_pause();
    test_reset_mid();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
